// File: rtl/line_follow_pkg.sv
// Shared encodings for the line-follower motion controller: driver directions,
// circuit codes, controller states and the saturating duty helper.
package line_follow_pkg;

  localparam logic [1:0] DIR_FWD  = 2'b10;
  localparam logic [1:0] DIR_REV  = 2'b01;
  localparam logic [1:0] DIR_STOP = 2'b00;

  localparam logic [1:0] CIRC_IDLE      = 2'b00;
  localparam logic [1:0] CIRC_STRAIGHT  = 2'b01;
  localparam logic [1:0] CIRC_CURVES    = 2'b10;
  localparam logic [1:0] CIRC_ENDURANCE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FOLLOW,
    ST_SEARCH,
    ST_LOST,
    ST_DONE
  } state_e;

  // Full duty minus off*step, floored at zero.
  function automatic int sat_sub(input int full, input int step, input int off);
    return (off * step >= full) ? 0 : full - off * step;
  endfunction

endpackage

// File: rtl/lf_debounce.sv
// Symmetric level debouncer: the level must differ from the stable value for N
// consecutive cycles to flip it; a rising flip emits a one-cycle pulse.
module lf_debounce #(
  parameter int N = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic level_i,
  output logic rise_o
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  logic [CW-1:0] cnt_q;
  logic          stable_q;
  logic          rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else if (clr_i) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      // Any sample agreeing with the stable value restarts the count.
      if (level_i == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(N - 1)) begin
        cnt_q    <= '0;
        stable_q <= level_i;
        rise_q   <= level_i;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-follower motion controller: synchronised sensors steer two PWM drivers,
// a timed pivot searches for a lost line, and a debounced finish line counts laps.
module line_follow_ctrl
  import line_follow_pkg::*;
#(
  parameter int NUM_SENSORS = 5,
  parameter int DUTY_W      = 12,
  parameter int DUTY_FULL   = 'h999,
  parameter int DUTY_STEP   = 'h300,
  parameter int DUTY_SEARCH = 'h600,
  parameter int SEARCH_TO   = 50000,
  parameter int FINISH_DEB  = 1000,
  parameter int LAP_W       = 8,
  parameter int LAPS_C1     = 1,
  parameter int LAPS_C2     = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SENSORS-1:0] sensors,
  input  logic [1:0]             circuit,
  output logic [1:0]             dir_a,
  output logic [1:0]             dir_b,
  output logic [DUTY_W-1:0]      duty_a,
  output logic [DUTY_W-1:0]      duty_b,
  output logic                   sig_right,
  output logic                   sig_left,
  output logic                   brake,
  output logic [LAP_W-1:0]       lap_count,
  output logic                   lap_tick,
  output logic                   lost
);
  localparam int N  = NUM_SENSORS;
  localparam int C  = (N - 1) / 2;
  localparam int TW = (SEARCH_TO > 2) ? $clog2(SEARCH_TO) : 1;

  logic [N-1:0]        sync1_q, sync2_q;
  state_e              state_q, state_d;
  logic                last_left_q, last_left_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [LAP_W-1:0]    lap_q, lap_d;
  logic                tick_q, tick_d;
  logic [1:0]          dir_a_q, dir_a_d, dir_b_q, dir_b_d;
  logic [DUTY_W-1:0]   duty_a_q, duty_a_d, duty_b_q, duty_b_d;
  logic                brake_q, lost_q, sig_r_q, sig_l_q;

  logic any_set, finish, right_hit, left_hit, fin_level, fin_rise, clr;
  int   r_off, l_off;

  assign clr       = (circuit == CIRC_IDLE);
  assign fin_level = finish && (state_q == ST_FOLLOW);

  lf_debounce #(.N(FINISH_DEB)) u_finish (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr),
    .level_i (fin_level),
    .rise_o  (fin_rise)
  );

  // Offsets: distance of the outermost hit on each side from the centre.
  always_comb begin
    any_set   = |sync2_q;
    finish    = sync2_q[0] & sync2_q[N-1];
    right_hit = |sync2_q[C-1:0];
    left_hit  = |sync2_q[N-1:C+1];
    r_off = 0;
    for (int i = C - 1; i >= 0; i--) if (sync2_q[i]) r_off = C - i;
    l_off = 0;
    for (int i = C + 1; i < N; i++) if (sync2_q[i]) l_off = i - C;
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    lap_d       = lap_q;
    tick_d      = 1'b0;
    last_left_d = last_left_q;
    dir_a_d     = DIR_STOP;
    dir_b_d     = DIR_STOP;
    duty_a_d    = '0;
    duty_b_d    = '0;

    case (state_q)
      ST_IDLE:   if (!clr && sync2_q[C]) state_d = ST_FOLLOW;
      ST_FOLLOW: if (!any_set) begin
        state_d = ST_SEARCH;
        timer_d = '0;
      end
      ST_SEARCH: begin
        if (any_set)                           state_d = ST_FOLLOW;
        else if (timer_q == TW'(SEARCH_TO - 1)) state_d = ST_LOST;
        else                                   timer_d = timer_q + 1'b1;
      end
      default: ;
    endcase

    if (fin_rise) begin
      lap_d  = (lap_q == '1) ? lap_q : lap_q + 1'b1;
      tick_d = 1'b1;
    end
    // The lap compare runs the cycle after an increment, against the current circuit.
    if (tick_q && (state_q == ST_FOLLOW || state_q == ST_SEARCH) &&
        ((circuit == CIRC_STRAIGHT && lap_q == LAP_W'(LAPS_C1)) ||
         (circuit == CIRC_CURVES   && lap_q == LAP_W'(LAPS_C2))))
      state_d = ST_DONE;
    if (clr) begin
      state_d = ST_IDLE;
      timer_d = '0;
      lap_d   = '0;
      tick_d  = 1'b0;
    end

    case (state_d)
      ST_FOLLOW: begin
        duty_a_d = DUTY_W'(DUTY_FULL);
        duty_b_d = DUTY_W'(DUTY_FULL);
        if (!finish && right_hit && !left_hit) begin
          duty_a_d    = DUTY_W'(sat_sub(DUTY_FULL, DUTY_STEP, r_off));
          last_left_d = 1'b0;
        end else if (!finish && left_hit && !right_hit) begin
          duty_b_d    = DUTY_W'(sat_sub(DUTY_FULL, DUTY_STEP, l_off));
          last_left_d = 1'b1;
        end
        dir_a_d = (duty_a_d == '0) ? DIR_STOP : DIR_FWD;
        dir_b_d = (duty_b_d == '0) ? DIR_STOP : DIR_FWD;
      end
      ST_SEARCH: begin
        dir_a_d  = last_left_q ? DIR_FWD : DIR_REV;
        dir_b_d  = last_left_q ? DIR_REV : DIR_FWD;
        duty_a_d = DUTY_W'(DUTY_SEARCH);
        duty_b_d = DUTY_W'(DUTY_SEARCH);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      state_q     <= ST_IDLE;
      last_left_q <= 1'b0;
      timer_q     <= '0;
      lap_q       <= '0;
      tick_q      <= 1'b0;
      dir_a_q     <= DIR_STOP;
      dir_b_q     <= DIR_STOP;
      duty_a_q    <= '0;
      duty_b_q    <= '0;
      brake_q     <= 1'b1;
      lost_q      <= 1'b0;
      sig_r_q     <= 1'b0;
      sig_l_q     <= 1'b0;
    end else begin
      sync1_q     <= sensors;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      last_left_q <= last_left_d;
      timer_q     <= timer_d;
      lap_q       <= lap_d;
      tick_q      <= tick_d;
      dir_a_q     <= dir_a_d;
      dir_b_q     <= dir_b_d;
      duty_a_q    <= duty_a_d;
      duty_b_q    <= duty_b_d;
      brake_q     <= (state_d != ST_FOLLOW);
      lost_q      <= (state_d == ST_LOST);
      sig_r_q     <= sync2_q[0];
      sig_l_q     <= sync2_q[N-1];
    end
  end

  assign dir_a     = dir_a_q;
  assign dir_b     = dir_b_q;
  assign duty_a    = duty_a_q;
  assign duty_b    = duty_b_q;
  assign sig_right = sig_r_q;
  assign sig_left  = sig_l_q;
  assign brake     = brake_q;
  assign lost      = lost_q;
  assign lap_count = lap_q;
  assign lap_tick  = tick_q;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Bench for line_follow_ctrl: scenario tasks push expected output vectors to a
// queue when they drive stimulus and pop/compare when the outputs settle.
module tb_line_follow_ctrl;
  localparam int NS = 5;
  localparam int DW = 12;
  localparam int LW = 8;
  localparam int STO = 40;
  localparam int DEB = 10;
  localparam int W = 2 + 2 + DW + DW + 1 + 1 + 1 + 1 + LW + 1;
  localparam int HOLD = DEB + 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NS-1:0] sensors = '0;
  logic [1:0]    circuit = 2'b00;
  logic [1:0]    dir_a, dir_b;
  logic [DW-1:0] duty_a, duty_b;
  logic          sig_right, sig_left, brake, lost, lap_tick;
  logic [LW-1:0] lap_count;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got, exp_v;
  int checks = 0;
  int errors = 0;
  int ticks_seen = 0;
  int exp_ticks = 0;

  line_follow_ctrl #(
    .NUM_SENSORS(NS), .DUTY_W(DW), .DUTY_FULL('h999), .DUTY_STEP('h300),
    .DUTY_SEARCH('h600), .SEARCH_TO(STO), .FINISH_DEB(DEB), .LAP_W(LW),
    .LAPS_C1(1), .LAPS_C2(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sensors(sensors), .circuit(circuit),
    .dir_a(dir_a), .dir_b(dir_b), .duty_a(duty_a), .duty_b(duty_b),
    .sig_right(sig_right), .sig_left(sig_left), .brake(brake),
    .lap_count(lap_count), .lap_tick(lap_tick), .lost(lost)
  );

  // Clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && lap_tick) ticks_seen++;

  function automatic logic [W-1:0] mk(input logic [1:0] da, input logic [1:0] db,
                                      input int pa, input int pb, input logic sr,
                                      input logic sl, input logic br, input logic lo,
                                      input int lap, input logic tk);
    return {da, db, DW'(pa), DW'(pb), sr, sl, br, lo, LW'(lap), tk};
  endfunction

  function automatic logic [W-1:0] pack_out();
    return {dir_a, dir_b, duty_a, duty_b, sig_right, sig_left, brake, lost, lap_count, lap_tick};
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NS-1:0] s, input logic [1:0] c);
    sensors = s;
    circuit = c;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    exp_q.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0));
    wait_clk(2);
    got = pack_out(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL reset got=%h exp=%h", got, exp_v); end
    rst_n = 1'b1;
    wait_clk(1);
  endtask

  task automatic test_follow();
    drive(5'b00100, 2'b01);
    exp_q.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0));
    exp_q.push_back(mk(2'b10, 2'b10, 'h999, 'h999, 0, 0, 0, 0, 0, 0));
    wait_clk(2);
    got = pack_out(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL follow_latency2 got=%h exp=%h", got, exp_v); end
    wait_clk(1);
    got = pack_out(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL follow_centre got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_steer();
    logic [NS-1:0] pat[6];
    logic [W-1:0]  ev[6];
    pat[0] = 5'b00010; ev[0] = mk(2'b10, 2'b10, 'h699, 'h999, 0, 0, 0, 0, 0, 0);
    pat[1] = 5'b01000; ev[1] = mk(2'b10, 2'b10, 'h999, 'h699, 0, 0, 0, 0, 0, 0);
    pat[2] = 5'b10000; ev[2] = mk(2'b10, 2'b10, 'h999, 'h399, 0, 1, 0, 0, 0, 0);
    pat[3] = 5'b00110; ev[3] = mk(2'b10, 2'b10, 'h699, 'h999, 0, 0, 0, 0, 0, 0);
    pat[4] = 5'b01110; ev[4] = mk(2'b10, 2'b10, 'h999, 'h999, 0, 0, 0, 0, 0, 0);
    pat[5] = 5'b00001; ev[5] = mk(2'b10, 2'b10, 'h399, 'h999, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(pat[i], 2'b01);
      exp_q.push_back(ev[i]);
      wait_clk(3);
      got = pack_out(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL steer_%b got=%h exp=%h", pat[i], got, exp_v); end
    end
  endtask

  task automatic test_search_lost();
    drive(5'b00000, 2'b01);
    exp_q.push_back(mk(2'b01, 2'b10, 'h600, 'h600, 0, 0, 1, 0, 0, 0));
    exp_q.push_back(mk(2'b01, 2'b10, 'h600, 'h600, 0, 0, 1, 0, 0, 0));
    exp_q.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0));
    exp_q.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0));
    wait_clk(3);
    got = pack_out(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL search_right got=%h exp=%h", got, exp_v); end
    wait_clk(STO - 1);
    got = pack_out(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL search_last got=%h exp=%h", got, exp_v); end
    wait_clk(1);
    got = pack_out(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL lost got=%h exp=%h", got, exp_v); end
    drive(5'b00000, 2'b00);
    wait_clk(1);
    got = pack_out(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL lost_clear got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_search_left();
    drive(5'b00100, 2'b01);
    wait_clk(3);
    drive(5'b10000, 2'b01);
    wait_clk(3);
    drive(5'b00000, 2'b01);
    exp_q.push_back(mk(2'b10, 2'b01, 'h600, 'h600, 0, 0, 1, 0, 0, 0));
    wait_clk(3);
    got = pack_out(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL search_left got=%h exp=%h", got, exp_v); end
    drive(5'b00100, 2'b01);
    exp_q.push_back(mk(2'b10, 2'b10, 'h999, 'h999, 0, 0, 0, 0, 0, 0));
    wait_clk(3);
    got = pack_out(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL search_reacquire got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_glitch();
    drive(5'b11111, 2'b10);
    wait_clk(DEB - 1);
    drive(5'b00100, 2'b10);
    wait_clk(1);
    drive(5'b11111, 2'b10);
    wait_clk(DEB - 1);
    drive(5'b00100, 2'b10);
    exp_q.push_back(mk(2'b10, 2'b10, 'h999, 'h999, 0, 0, 0, 0, 0, 0));
    wait_clk(HOLD);
    got = pack_out(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL glitch_no_lap got=%h exp=%h", got, exp_v); end
    checks++;
    if (ticks_seen !== exp_ticks) begin errors++; $display("FAIL glitch_ticks got=%0d exp=%0d", ticks_seen, exp_ticks); end
  endtask

  task automatic test_laps();
    for (int i = 1; i <= 10; i++) begin
      drive(5'b11111, 2'b10);
      exp_ticks++;
      if (i < 10) exp_q.push_back(mk(2'b10, 2'b10, 'h999, 'h999, 1, 1, 0, 0, i, 0));
      else        exp_q.push_back(mk(2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 10, 0));
      wait_clk(HOLD);
      got = pack_out(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL lap_%0d_set got=%h exp=%h", i, got, exp_v); end
      drive(5'b00100, 2'b10);
      if (i < 10) exp_q.push_back(mk(2'b10, 2'b10, 'h999, 'h999, 0, 0, 0, 0, i, 0));
      else        exp_q.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 10, 0));
      wait_clk(HOLD);
      got = pack_out(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL lap_%0d_clear got=%h exp=%h", i, got, exp_v); end
    end
  endtask

  task automatic test_done_clear();
    drive(5'b00100, 2'b00);
    exp_q.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0));
    wait_clk(1);
    got = pack_out(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL done_clear got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_straight();
    drive(5'b00100, 2'b01);
    wait_clk(3);
    drive(5'b11111, 2'b01);
    exp_ticks++;
    exp_q.push_back(mk(2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 1, 0));
    exp_q.push_back(mk(2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 0, 0));
    wait_clk(HOLD);
    got = pack_out(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL straight_done got=%h exp=%h", got, exp_v); end
    drive(5'b11111, 2'b00);
    wait_clk(1);
    got = pack_out(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL straight_clear got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_async_reset();
    drive(5'b00100, 2'b10);
    exp_q.push_back(mk(2'b10, 2'b10, 'h999, 'h999, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0));
    wait_clk(3);
    got = pack_out(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL pre_reset_follow got=%h exp=%h", got, exp_v); end
    #2 rst_n = 1'b0;
    #1;
    got = pack_out(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL async_reset got=%h exp=%h", got, exp_v); end
    wait_clk(2);
    rst_n = 1'b1;
  endtask

  task automatic test_tick_total();
    checks++;
    if (ticks_seen !== exp_ticks) begin errors++; $display("FAIL tick_total got=%0d exp=%0d", ticks_seen, exp_ticks); end
  endtask

  initial begin
    test_reset();
    test_follow();
    test_steer();
    test_search_lost();
    test_search_left();
    test_glitch();
    test_laps();
    test_done_clear();
    test_straight();
    test_async_reset();
    test_tick_total();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
